// File: rtl/ex_flag_pkg.sv
// Shared types and constants for the execute-stage flag unit.
package ex_flag_pkg;

  localparam int WIDTH = 16;

  localparam int Z_IDX = 2;
  localparam int V_IDX = 1;
  localparam int N_IDX = 0;

  typedef enum logic [1:0] {
    FLAG_NONE  = 2'b00,
    FLAG_ARITH = 2'b01,
    FLAG_LOGIC = 2'b10,
    FLAG_RSVD  = 2'b11
  } flag_op_t;

  typedef enum logic [2:0] {
    BR_NE = 3'b000,
    BR_EQ = 3'b001,
    BR_GT = 3'b010,
    BR_LT = 3'b011,
    BR_GE = 3'b100,
    BR_LE = 3'b101,
    BR_OV = 3'b110,
    BR_UN = 3'b111
  } br_cond_t;

endpackage

// File: rtl/ex_flag_stage_br_cond_eval.sv
// Combinational branch-condition decode of {Z,V,N} against a 3-bit condition code.
module br_cond_eval
  import ex_flag_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] br_cond,
  output logic       br_taken
);

  logic z;
  logic v;
  logic n;

  assign z = flags[Z_IDX];
  assign v = flags[V_IDX];
  assign n = flags[N_IDX];

  // Condition-code decode
  always_comb begin
    br_taken = 1'b0;
    case (br_cond_t'(br_cond))
      BR_NE:   br_taken = ~z;
      BR_EQ:   br_taken = z;
      BR_GT:   br_taken = ~z & ~n;
      BR_LT:   br_taken = n;
      BR_GE:   br_taken = z | ~n;
      BR_LE:   br_taken = n | z;
      BR_OV:   br_taken = v;
      BR_UN:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register and Z/V/N flag unit. Optional macro FLAG_BYPASS_EN lets
// br_taken see the flags being committed this cycle instead of only the committed flags.
module ex_flag_stage
  import ex_flag_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_result,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       flags,
  input  logic [2:0]       br_cond,
  output logic             br_taken
);

  logic             commit;
  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;
  logic             ovf;
  logic             zero;
  logic [2:0]       next_flags;
  logic [2:0]       eval_flags;

  assign commit = in_valid & ~stall & ~flush;

  // Overflow comes from the wrapped sum, since in_result may already be saturated.
  assign raw   = in_sub ? (in_a - in_b) : (in_a + in_b);
  assign a_msb = in_a[WIDTH-1];
  assign b_msb = in_b[WIDTH-1];
  assign ovf   = in_sub ? ((a_msb != b_msb) & (raw[WIDTH-1] != a_msb))
                        : ((a_msb == b_msb) & (raw[WIDTH-1] != a_msb));
  assign zero  = (in_result == {WIDTH{1'b0}});

  // Next-flag selection by flag class
  always_comb begin
    next_flags = flags;
    if (commit) begin
      case (flag_op_t'(in_op))
        FLAG_ARITH: begin
          next_flags[Z_IDX] = zero;
          next_flags[V_IDX] = ovf;
          next_flags[N_IDX] = in_result[WIDTH-1];
        end
        FLAG_LOGIC: next_flags[Z_IDX] = zero;
        default:    next_flags = flags;
      endcase
    end else begin
      next_flags = flags;
    end
  end

  // Pipeline register and architectural flags; stall beats flush beats in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= {WIDTH{1'b0}};
      flags      <= FLAG_RST;
    end else begin
      if (!stall) begin
        if (flush) begin
          out_valid <= 1'b0;
        end else begin
          out_valid  <= in_valid;
          out_result <= in_result;
        end
      end
      flags <= next_flags;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign eval_flags = next_flags;
`else
  assign eval_flags = flags;
`endif

  br_cond_eval u_br_cond_eval (
    .flags    (eval_flags),
    .br_cond  (br_cond),
    .br_taken (br_taken)
  );

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: expected pipeline/flag state queued at drive time.
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_op;
  logic        in_sub;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] in_result;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_result;
  logic [2:0]  flags;
  logic [2:0]  br_cond;
  logic        br_taken;

  typedef struct {
    logic        valid;
    logic [15:0] result;
    logic [2:0]  flags;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_valid;
  logic [15:0] m_result;
  logic [2:0]  m_flags;

  ex_flag_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_sub     (in_sub),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_result  (in_result),
    .stall      (stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_result (out_result),
    .flags      (flags),
    .br_cond    (br_cond),
    .br_taken   (br_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exact(input logic [15:0] a, input logic [15:0] b, input logic sb);
    int sa;
    int sbv;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    return sb ? (sa - sbv) : (sa + sbv);
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] a, input logic [15:0] b, input logic sb);
    int s;
    s = exact(a, b, sb);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Reference condition table, flags ordered {Z,V,N}
  function automatic logic cond_ref(input logic [2:0] f, input logic [2:0] c);
    logic z;
    logic v;
    logic n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input logic v, input logic [1:0] op, input logic sb,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                      input logic st, input logic fl, input logic [2:0] cond);
    logic       commit;
    logic       nv;
    int         s;
    logic [2:0] nf;
    logic [2:0] ef;
    exp_t       e;
    in_valid = v; in_op = op; in_sub = sb; in_a = a; in_b = b; in_result = r;
    stall = st; flush = fl; br_cond = cond;
    commit = v && !st && !fl;
    s  = exact(a, b, sb);
    nv = (s > 32767) || (s < -32768);
    nf = m_flags;
    if (commit && op == 2'b01) nf = {(r == 16'h0000), nv, r[15]};
    else if (commit && op == 2'b10) nf[2] = (r == 16'h0000);
    ef = m_flags;
`ifdef FLAG_BYPASS_EN
    ef = nf;
`endif
    @(negedge clk);
    check("br_taken", {15'b0, br_taken}, {15'b0, cond_ref(ef, cond)});
    if (!st) begin
      if (fl) m_valid = 1'b0;
      else begin
        m_valid  = v;
        m_result = r;
      end
    end
    m_flags  = nf;
    e.valid  = m_valid;
    e.result = m_result;
    e.flags  = m_flags;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      check("out_valid", {15'b0, out_valid}, {15'b0, e.valid});
      check("out_result", out_result, e.result);
      check("flags", {13'b0, flags}, {13'b0, e.flags});
    end
  endtask

  task automatic arith(input logic sb, input logic [15:0] a, input logic [15:0] b, input logic [2:0] cond);
    step(1'b1, 2'b01, sb, a, b, sat(a, b, sb), 1'b0, 1'b0, cond);
  endtask

  task automatic idle(input logic [2:0] cond);
    step(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, cond);
  endtask

  task automatic check_reset_state();
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_result", out_result, 16'h0000);
    check("rst_flags", {13'b0, flags}, 16'h0000);
    check("rst_br_ne", {15'b0, br_taken}, 16'h0001);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_sub = 1'b0;
    in_a = 16'h0000; in_b = 16'h0000; in_result = 16'h0000;
    stall = 1'b0; flush = 1'b0; br_cond = 3'b000;
    m_valid = 1'b0; m_result = 16'h0000; m_flags = 3'b000;
    #12;
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    arith(1'b0, 16'h7000, 16'h2000, 3'b110);   // saturate to 7FFF: Z0 V1 N0
    arith(1'b1, 16'h8000, 16'h0001, 3'b110);   // saturate to 8000: Z0 V1 N1
    idle(3'b110);
    step(1'b1, 2'b10, 1'b0, 16'h1234, 16'h4321, 16'h0000, 1'b0, 1'b0, 3'b001);
    idle(3'b001);
    arith(1'b1, 16'h8000, 16'h8000, 3'b011);   // Z1 V0 N0
    arith(1'b0, 16'h8000, 16'hFFFF, 3'b101);   // add-side negative saturation
    arith(1'b0, 16'h0001, 16'h0002, 3'b010);   // back-to-back
    arith(1'b1, 16'h0001, 16'h0002, 3'b011);

    for (int i = 0; i < 3; i++)
      step(1'b1, 2'b01, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b1, 1'b0, 3'b100);
    arith(1'b0, 16'h0005, 16'h0003, 3'b010);
    step(1'b1, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3'b001);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b001);
    step(1'b1, 2'b00, 1'b1, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 3'b001);

    arith(1'b1, 16'h0003, 16'h0003, 3'b001);   // bypass-sensitive EQ
    idle(3'b001);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] rr;
      ra = 16'($urandom());
      rb = 16'($urandom());
      if (i % 4 == 3) begin
        rr = (i % 8 == 3) ? 16'h0000 : (ra & rb);
        step(1'b1, 2'b10, 1'b0, ra, rb, rr, 1'b0, 1'b0, 3'($urandom_range(7, 0)));
      end else begin
        arith(1'($urandom_range(1, 0)), ra, rb, 3'($urandom_range(7, 0)));
      end
    end

    arith(1'b1, 16'h8000, 16'h0001, 3'b110);
    in_valid = 1'b1; in_op = 2'b01; stall = 1'b1; br_cond = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    m_valid = 1'b0; m_result = 16'h0000; m_flags = 3'b000;
    @(posedge clk); #1;
    check_reset_state();
    rst_n = 1'b1;
    arith(1'b0, 16'hFFFF, 16'h0001, 3'b001);   // wraps to 0 without overflow

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Execute-stage register and flag unit downstream of addsub_16bit.
- Captures the saturated 16-bit ALU result with its operands and computes the Z/V/N condition flags.
- Holds the architectural flag register and registers the result into the EX/MEM boundary.
- Evaluates 3-bit branch conditions against the committed flags for the branch unit.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- FLAG_RST, 3'b000, reset value of {Z,V,N}.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX stage holds a valid instruction
- in_op  in  2  flag class (ex_flag_pkg::flag_op_t): 00 NONE, 01 ARITH, 10 LOGIC, 11 reserved (treated as NONE)
- in_sub  in  1  subtract select, same value driven into addsub_16bit Sub
- in_a  in  16  operand A as presented to addsub_16bit
- in_b  in  16  operand B as presented to addsub_16bit
- in_result  in  16  ALU result (saturated Sum for ARITH)
- stall  in  1  hold the pipeline register and flags
- flush  in  1  squash the instruction currently in EX
- out_valid  out  1  registered valid
- out_result  out  16  registered result
- flags  out  3  committed {Z,V,N}
- br_cond  in  3  branch condition code
- br_taken  out  1  condition true against committed flags (combinational)

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_result=16'h0000, flags=FLAG_RST. br_taken follows the reset flags.
- Commit condition: commit = in_valid & ~stall & ~flush.
- Pipeline register, on each rising edge:
  - if stall: hold out_valid and out_result;
  - else if flush: out_valid<=0, out_result holds;
  - else: out_valid<=in_valid and out_result<=in_result.
  - flush has priority over in_valid; stall has priority over flush.
- Latency: 1 cycle, in_* to out_*.
- Next-flag computation:
  - Z: in_result==0.
  - N: in_result[15].
  - V for add: raw=in_a+in_b (mod 2^16); V=(a15==b15)&(raw15!=a15).
  - V for sub: raw=in_a-in_b; V=(a15!=b15)&(raw15!=a15).
  - V is computed from the wrapped raw result, never from the saturated in_result.
- Flag update on commit:
  - ARITH: Z, V, N all update.
  - LOGIC: Z updates; V and N hold.
  - NONE/reserved: all flags hold.
  - Without commit: flags hold.
- br_cond decode (uses committed flags):
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z&~N
  - 011 LT: N
  - 100 GE: Z|~N
  - 101 LE: N|Z
  - 110 OV: V
  - 111 UN: 1
- Boundary cases:
  - Saturation at 7FFF or 8000: Z=0, V=1, N=result sign.
  - Sub 0x8000-0x8000: V=0, Z=1.
  - Back-to-back ARITH commits: each updates in order.
  - Reset mid-stall: flags and pipeline clear immediately.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: br_taken evaluates against next flags whenever commit is high, so a branch can use flags set by the instruction in EX in the same cycle.
- Undefined: br_taken uses committed flags only; the hazard unit must stall one cycle.

Decomposition:
- ex_flag_pkg holds:
  - flag_op_t enum;
  - br_cond_t enum (NE..UN);
  - flag bit-index constants Z_IDX=2, V_IDX=1, N_IDX=0;
  - WIDTH constant.
- Sub-module: br_cond_eval, a combinational decode of {Z,V,N} and br_cond to br_taken.

Test Plan:
- ARITH add 7000+2000, in_result=7FFF, commit -> next cycle flags Z=0 V=1 N=0, out_result=7FFF, out_valid=1.
- ARITH sub 8000-0001, in_result=8000 -> flags Z=0 V=1 N=1; br_cond=110 -> br_taken=1.
- LOGIC in_result=0000 after the previous case -> Z=1, V=1 and N=1 held; br_cond=001 -> 1.
- stall=1 with ARITH 0005+0003 -> flags and out_* unchanged for 3 cycles; releasing stall commits Z=0 V=0 N=0, out_result=0008.
- flush=1 with ARITH 0000+0000 -> out_valid=0, flags unchanged.
- rst_n low mid-operation -> immediately out_valid=0, out_result=0000, flags=000.
- With FLAG_BYPASS_EN: ARITH 0003-0003, in_result=0000, br_cond=001 -> br_taken=1 in the same cycle. Without it -> br_taken=1 one cycle later.
